// File: rtl/ram_bist.sv
// March C- style self-test master for a single-port RAM (w P / r P,w ~P / r ~P,w P / r P).
// It drives the RAM directly and reports pass/fail and the first failing location.
module ram_bist #(
  parameter int                ADDR_W  = 8,
  parameter int                DATA_W  = 8,
  parameter logic [DATA_W-1:0] PATTERN = 8'h55
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_exp,
  output logic [DATA_W-1:0] fail_got,
  output logic              ram_rd,
  output logic              ram_wr,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_d_in,
  input  logic [DATA_W-1:0] ram_d_out
);

  // Handshake: start is a request taken only in IDLE/DONE; busy covers the whole
  // march, and done/pass/fail_* hold the result until the next accepted start.
  typedef enum logic [3:0] {
    IDLE, M0_W, M1_RD, M1_CW, M2_RD, M2_CW, M3_RD, M3_CK, DONE
  } state_t;

  localparam logic [ADDR_W-1:0] A_MAX  = '1;
  localparam logic [ADDR_W-1:0] A_ZERO = '0;
  localparam logic [ADDR_W-1:0] A_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t              state, state_nx;
  logic [ADDR_W-1:0]   a, a_nx;
  logic                start_pend;
  logic                accept;
  logic                mismatch;
  logic                last_ok;
  logic [DATA_W-1:0]   exp_data;

  assign busy   = (state != IDLE) && (state != DONE);
  assign accept = start && !busy && !start_pend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      a          <= A_ZERO;
      start_pend <= 1'b0;
    end else begin
      state      <= state_nx;
      a          <= a_nx;
      start_pend <= accept;
    end
  end

  // ram_* depend only on state and a; ram_d_out only steers the next state.
  always_comb begin
    state_nx = state;
    a_nx     = a;
    ram_rd   = 1'b0;
    ram_wr   = 1'b0;
    ram_addr = A_ZERO;
    ram_d_in = '0;
    exp_data = '0;
    mismatch = 1'b0;
    last_ok  = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start_pend) begin
          state_nx = M0_W;
          a_nx     = A_ZERO;
        end
      end
      M0_W: begin
        ram_wr   = 1'b1;
        ram_addr = a;
        ram_d_in = PATTERN;
        if (a == A_MAX) begin
          state_nx = M1_RD;
          a_nx     = A_ZERO;
        end else begin
          a_nx = a + A_ONE;
        end
      end
      M1_RD: begin
        ram_rd   = 1'b1;
        ram_addr = a;
        state_nx = M1_CW;
      end
      M1_CW: begin
        ram_wr   = 1'b1;
        ram_addr = a;
        ram_d_in = ~PATTERN;
        exp_data = PATTERN;
        mismatch = (ram_d_out != exp_data);
        if (mismatch) begin
          state_nx = DONE;
        end else if (a == A_MAX) begin
          state_nx = M2_RD;
          a_nx     = A_MAX;
        end else begin
          state_nx = M1_RD;
          a_nx     = a + A_ONE;
        end
      end
      M2_RD: begin
        ram_rd   = 1'b1;
        ram_addr = a;
        state_nx = M2_CW;
      end
      M2_CW: begin
        ram_wr   = 1'b1;
        ram_addr = a;
        ram_d_in = PATTERN;
        exp_data = ~PATTERN;
        mismatch = (ram_d_out != exp_data);
        if (mismatch) begin
          state_nx = DONE;
        end else if (a == A_ZERO) begin
          state_nx = M3_RD;
          a_nx     = A_MAX;
        end else begin
          state_nx = M2_RD;
          a_nx     = a - A_ONE;
        end
      end
      M3_RD: begin
        ram_rd   = 1'b1;
        ram_addr = a;
        state_nx = M3_CK;
      end
      M3_CK: begin
        exp_data = PATTERN;
        mismatch = (ram_d_out != exp_data);
        if (mismatch) begin
          state_nx = DONE;
        end else if (a == A_ZERO) begin
          state_nx = DONE;
          last_ok  = 1'b1;
        end else begin
          state_nx = M3_RD;
          a_nx     = a - A_ONE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_addr <= A_ZERO;
      fail_exp  <= '0;
      fail_got  <= '0;
    end else if (accept) begin
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_addr <= A_ZERO;
      fail_exp  <= '0;
      fail_got  <= '0;
    end else if (mismatch) begin
      done      <= 1'b1;
      pass      <= 1'b0;
      fail_addr <= a;
      fail_exp  <= exp_data;
      fail_got  <= ram_d_out;
    end else if (last_ok) begin
      done <= 1'b1;
      pass <= 1'b1;
    end
  end

endmodule
